auth_session_ctrl: RTL
======================

Name: auth_session_ctrl

Overview:
Session controller between the Authentication block and the GameController. Sequences the login flow and counts failed ID/PW attempts, with lockout after repeated failures. Enforces an inactivity timeout and a guest play-time limit. Merges logout sources into a single log_in session flag and clears Authentication between sessions.

Parameters:
MAX_FAILS, 3, consecutive failed attempts (ID or PW) before lockout
LOCK_CYCLES, 500, clk cycles spent in LOCKED
IDLE_TIMEOUT, 3000, clk cycles without activity before forced logout (SESSION) or entry abort (ENTRY)
GUEST_LIMIT, 6000, maximum clk cycles of a guest session
CNT_W, 16, width of the shared timer; all cycle parameters must be < 2**CNT_W

Ports:
clk  in  1  system clock (50 MHz)
rst  in  1  reset; synchronous, active-high
auth_pass  in  1  one-cycle pulse from Authentication: ID+PW accepted
auth_fail  in  1  one-cycle pulse from Authentication: ID or PW rejected
auth_guest  in  1  guest flag from Authentication, valid with auth_pass
auth_id  in  3  user index from Authentication, valid with auth_pass
pwenter  in  1  one-cycle pulse, user pressed enter (activity)
game_activity  in  1  one-cycle pulse from GameController (activity)
log_out_ctrl  in  1  logout request from GameController, level or pulse
auth_en  out  1  high while Authentication may accept digits
auth_clr  out  1  one-cycle pulse that clears the Authentication FSM
log_in_ctrl  out  1  high for the whole logged-in session
isGuest_ctrl  out  1  registered auth_guest, valid while log_in_ctrl
intID_ctrl  out  3  registered auth_id, valid while log_in_ctrl
locked_out  out  1  high in LOCKED
timeout_evt  out  1  one-cycle pulse on inactivity or guest-limit expiry

Behaviour:
- Reset: state=IDLE, all outputs 0 except auth_clr=1 in the cycle after rst deasserts. fail_cnt=0, timer=0. rst has priority over every input in every state.
- States: IDLE, ENTRY, LOCKED, SESSION, LOGOUT.
- IDLE: auth_en=1, timer=0. pwenter -> ENTRY, timer cleared.
- ENTRY: auth_en=1. timer increments each cycle and clears on pwenter.
  - auth_pass -> SESSION next cycle. Capture auth_guest/auth_id, fail_cnt=0, timer=0, log_in_ctrl=1 from that edge.
  - auth_fail -> fail_cnt+1. If the new value == MAX_FAILS: go to LOCKED, auth_clr pulse, fail_cnt=0, timer=0. Otherwise stay in ENTRY with timer=0.
  - timer reaches IDLE_TIMEOUT-1 -> IDLE, auth_clr pulse, timeout_evt pulse. fail_cnt is retained.
  - Simultaneous auth_pass and auth_fail: auth_fail wins; this is a protocol error.
- LOCKED: auth_en=0, locked_out=1. auth_pass/auth_fail/pwenter ignored. After LOCK_CYCLES cycles (timer == LOCK_CYCLES-1) -> IDLE, auth_clr pulse.
- SESSION: log_in_ctrl=1, auth_en=0. timer clears on pwenter or game_activity. A separate guest counter runs only when isGuest_ctrl=1.
  - Priority 1: log_out_ctrl=1 -> LOGOUT.
  - Priority 2: idle timer == IDLE_TIMEOUT-1 or guest counter == GUEST_LIMIT-1 -> LOGOUT, with timeout_evt pulse in the same cycle as the transition.
  - auth_pass/auth_fail in SESSION are ignored.
- LOGOUT: exactly one cycle. log_in_ctrl=0, isGuest_ctrl=0, intID_ctrl=0, auth_clr=1. Next state is IDLE, but remains LOGOUT while log_out_ctrl is held high. This makes a level request yield exactly one session end.
- Latency: log_in_ctrl rises 1 cycle after auth_pass. log_in_ctrl falls 1 cycle after log_out_ctrl is sampled high.
- Counters saturate and never wrap. fail_cnt width is clog2(MAX_FAILS+1).
- All outputs are registered; no combinational input-to-output path.

Decomposition:
- Shared package auth_pkg:
  - state encoding constants (ST_IDLE..ST_LOGOUT, 3-bit)
  - ID width (3)
  - default timeout constants, for reuse by GameController and the bench
- One sub-module, sat_timer: a CNT_W saturating counter with clear, enable and terminal-count compare. Instantiated twice: the idle/lock timer and the guest timer.

Test Plan:
- Reset then pwenter then auth_pass(id=3'd2, guest=0) -> log_in_ctrl=1 and intID_ctrl=2 one cycle after auth_pass; auth_en=0.
- Three auth_fail pulses in ENTRY -> locked_out=1 after the third, with auth_clr pulse; stays locked exactly LOCK_CYCLES cycles; auth_pass during lock is ignored; then returns to IDLE with auth_en=1.
- Two fails, then auth_pass -> SESSION and fail_cnt cleared. A following fail sequence needs 3 more fails to lock.
- SESSION with no activity for IDLE_TIMEOUT cycles -> timeout_evt single pulse, LOGOUT, then IDLE. game_activity every 100 cycles keeps the session alive indefinitely (non-guest).
- Guest login (auth_guest=1) with continuous game_activity -> forced logout at GUEST_LIMIT cycles; isGuest_ctrl and intID_ctrl return to 0.
- log_out_ctrl held high 9 cycles -> exactly one log_in_ctrl falling edge and one auth_clr pulse. rst asserted mid-SESSION -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/auth_pkg.sv
// auth_pkg: shared state encoding, user id width and default session timing
package auth_pkg;
   localparam int ID_W             = 3;
   localparam int DEF_MAX_FAILS    = 3;
   localparam int DEF_LOCK_CYCLES  = 500;
   localparam int DEF_IDLE_TIMEOUT = 3000;
   localparam int DEF_GUEST_LIMIT  = 6000;
   localparam int DEF_CNT_W        = 16;
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ENTRY   = 3'd1,
      ST_LOCKED  = 3'd2,
      ST_SESSION = 3'd3,
      ST_LOGOUT  = 3'd4
   } state_t;
endpackage

// File: rtl/auth_session_ctrl_if.sv
// auth_session_ctrl_if: Authentication/GameController <-> session controller signals
// master drives auth_*, pwenter, game_activity, log_out_ctrl; slave (the controller) drives the rest
interface auth_session_ctrl_if;
   import auth_pkg::*;
   logic            auth_pass;
   logic            auth_fail;
   logic            auth_guest;
   logic [ID_W-1:0] auth_id;
   logic            pwenter;
   logic            game_activity;
   logic            log_out_ctrl;
   logic            auth_en;
   logic            auth_clr;
   logic            log_in_ctrl;
   logic            isGuest_ctrl;
   logic [ID_W-1:0] intID_ctrl;
   logic            locked_out;
   logic            timeout_evt;
   modport master (
      output auth_pass, auth_fail, auth_guest, auth_id, pwenter, game_activity, log_out_ctrl,
      input  auth_en, auth_clr, log_in_ctrl, isGuest_ctrl, intID_ctrl, locked_out, timeout_evt
   );
   modport slave (
      input  auth_pass, auth_fail, auth_guest, auth_id, pwenter, game_activity, log_out_ctrl,
      output auth_en, auth_clr, log_in_ctrl, isGuest_ctrl, intID_ctrl, locked_out, timeout_evt
   );
endinterface

// File: rtl/sat_timer.sv
// sat_timer: saturating up-counter with clear, enable and terminal-count compare
// ports: clk, rst, clr (zero next cycle), en (count), lim (compare value), hit (cnt == lim)
module sat_timer #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] lim,
   output logic         hit
);
   logic [W-1:0] cnt;
   always_ff @(posedge clk) begin
      if (rst || clr) cnt <= '0;
      else if (en && cnt != '1) cnt <= cnt + 1'b1;
   end
   assign hit = cnt == lim;
endmodule

// File: rtl/auth_session_ctrl.sv
// auth_session_ctrl: login sequencing, failed-attempt lockout, inactivity and guest time limits
// ports: clk, rst (sync, active-high), bus (slave side of auth_session_ctrl_if)
module auth_session_ctrl import auth_pkg::*; #(
   parameter int MAX_FAILS    = DEF_MAX_FAILS,
   parameter int LOCK_CYCLES  = DEF_LOCK_CYCLES,
   parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT,
   parameter int GUEST_LIMIT  = DEF_GUEST_LIMIT,
   parameter int CNT_W        = DEF_CNT_W
) (
   input logic                clk,
   input logic                rst,
   auth_session_ctrl_if.slave bus
);
   localparam int FW = $clog2(MAX_FAILS + 1);
   state_t           state, state_n;
   logic [FW-1:0]    fail_cnt, fail_cnt_n, fail_inc;
   logic             rst_q, t_clr, t_hit, g_clr, g_hit, clr_n, timeout_n;
   logic [CNT_W-1:0] t_lim;
   // one timer serves idle timeout and lock duration; only the compare value changes
   assign t_lim    = state == ST_LOCKED ? CNT_W'(LOCK_CYCLES - 1) : CNT_W'(IDLE_TIMEOUT - 1);
   assign g_clr    = !(state == ST_SESSION && bus.isGuest_ctrl);
   assign fail_inc = fail_cnt == FW'(MAX_FAILS) ? fail_cnt : fail_cnt + 1'b1;
   sat_timer #(.W(CNT_W)) u_idle_timer (
      .clk(clk), .rst(rst), .clr(t_clr), .en(1'b1), .lim(t_lim), .hit(t_hit)
   );
   sat_timer #(.W(CNT_W)) u_guest_timer (
      .clk(clk), .rst(rst), .clr(g_clr), .en(1'b1), .lim(CNT_W'(GUEST_LIMIT - 1)), .hit(g_hit)
   );
   always_comb begin
      state_n    = state;
      fail_cnt_n = fail_cnt;
      t_clr      = 1'b0;
      clr_n      = 1'b0;
      timeout_n  = 1'b0;
      case (state)
         ST_IDLE: begin
            t_clr = 1'b1;
            if (bus.pwenter) state_n = ST_ENTRY;
         end
         ST_ENTRY: begin
            t_clr = bus.pwenter;
            // a fail outranks a simultaneous pass
            if (bus.auth_fail) begin
               t_clr      = 1'b1;
               fail_cnt_n = fail_inc;
               if (fail_inc == FW'(MAX_FAILS)) begin
                  state_n    = ST_LOCKED;
                  fail_cnt_n = '0;
                  clr_n      = 1'b1;
               end
            end else if (bus.auth_pass) begin
               state_n    = ST_SESSION;
               fail_cnt_n = '0;
               t_clr      = 1'b1;
            end else if (t_hit) begin
               state_n   = ST_IDLE;
               t_clr     = 1'b1;
               clr_n     = 1'b1;
               timeout_n = 1'b1;
            end
         end
         ST_LOCKED: begin
            if (t_hit) begin
               state_n = ST_IDLE;
               t_clr   = 1'b1;
               clr_n   = 1'b1;
            end
         end
         ST_SESSION: begin
            t_clr = bus.pwenter | bus.game_activity;
            if (bus.log_out_ctrl || t_hit || g_hit) begin
               state_n   = ST_LOGOUT;
               t_clr     = 1'b1;
               clr_n     = 1'b1;
               timeout_n = !bus.log_out_ctrl;
            end
         end
         ST_LOGOUT: begin
            t_clr = 1'b1;
            // a held request parks here so it ends only one session
            if (!bus.log_out_ctrl) state_n = ST_IDLE;
         end
         default: begin
            t_clr   = 1'b1;
            state_n = ST_IDLE;
         end
      endcase
   end
   // outputs are registered from the next state so they line up with the state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= ST_IDLE;
         fail_cnt         <= '0;
         rst_q            <= 1'b1;
         bus.auth_en      <= 1'b0;
         bus.auth_clr     <= 1'b0;
         bus.log_in_ctrl  <= 1'b0;
         bus.isGuest_ctrl <= 1'b0;
         bus.intID_ctrl   <= '0;
         bus.locked_out   <= 1'b0;
         bus.timeout_evt  <= 1'b0;
      end else begin
         state            <= state_n;
         fail_cnt         <= fail_cnt_n;
         rst_q            <= 1'b0;
         bus.auth_en      <= state_n == ST_IDLE || state_n == ST_ENTRY;
         bus.auth_clr     <= clr_n | rst_q;
         bus.log_in_ctrl  <= state_n == ST_SESSION;
         bus.locked_out   <= state_n == ST_LOCKED;
         bus.timeout_evt  <= timeout_n;
         bus.isGuest_ctrl <= state_n != ST_SESSION ? 1'b0 : state == ST_SESSION ? bus.isGuest_ctrl : bus.auth_guest;
         bus.intID_ctrl   <= state_n != ST_SESSION ? '0 : state == ST_SESSION ? bus.intID_ctrl : bus.auth_id;
      end
   end
endmodule
